// File: rtl/video_scanlines_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_scanlines_pkg                                                        |
// | Shared types and the per-component dimming function for video_scanlines.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package video_scanlines_pkg;

  localparam int c_comp_w = 8;

  typedef enum logic [1:0] {
    SL_OFF = 2'd0,
    SL_25  = 2'd1,
    SL_50  = 2'd2,
    SL_75  = 2'd3
  } sl_mode_t;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } sl_parity_t;

  // Shift-only dimming: the sum of two right shifts of an 8-bit value cannot overflow.
  function automatic logic [c_comp_w-1:0] sl_dim(input logic [c_comp_w-1:0] c,
                                                 input sl_mode_t            mode);
    case (mode)
      SL_25:   return (c >> 1) + (c >> 2);
      SL_50:   return c >> 1;
      SL_75:   return c >> 2;
      default: return c;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_scanlines_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_scanlines_if                                                         |
// | Pixel-rate VGA stream into and out of the scanline stage.                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface video_scanlines_if;

  logic       CE_PIXEL;
  logic [1:0] scanlines;
  logic [7:0] VGA_R_in;
  logic [7:0] VGA_G_in;
  logic [7:0] VGA_B_in;
  logic       VGA_HS_in;
  logic       VGA_VS_in;
  logic       VGA_DE_in;

  logic       CE_PIXEL_out;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_DE;

  // Mixer side: drives the incoming stream, observes the processed stream.
  modport master (
    output CE_PIXEL, scanlines, VGA_R_in, VGA_G_in, VGA_B_in,
           VGA_HS_in, VGA_VS_in, VGA_DE_in,
    input  CE_PIXEL_out, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE
  );

  modport slave (
    input  CE_PIXEL, scanlines, VGA_R_in, VGA_G_in, VGA_B_in,
           VGA_HS_in, VGA_VS_in, VGA_DE_in,
    output CE_PIXEL_out, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE
  );

endinterface
`default_nettype wire

// File: rtl/video_scanlines_scanline_dim.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | scanline_dim                                                               |
// | One registered colour channel: blank, dim or pass one 8-bit component.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module scanline_dim
  import video_scanlines_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_ce,
  input  logic [c_comp_w-1:0] i_c,
  input  logic                i_dim,
  input  sl_mode_t            i_mode,
  input  logic                i_de,
  output logic [c_comp_w-1:0] o_c
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_c <= '0;
    end else if (i_ce) begin
      if (!i_de)
        o_c <= '0;
      else if (i_dim)
        o_c <= sl_dim(i_c, i_mode);
      else
        o_c <= i_c;
    end
  end

endmodule
`default_nettype wire

// File: rtl/video_scanlines.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | video_scanlines                                                            |
// | Darkens alternate output lines; one-pixel latency on colour, sync and DE.  |
// | Optional: VIDEO_SCANLINES_ALTPHASE_EN alternates dimmed lines per frame.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module video_scanlines
  import video_scanlines_pkg::*;
(
  input  logic               CLK_VIDEO,
  input  logic               reset,
  video_scanlines_if.slave   vid
);

  logic       r_old_hs;
  logic       r_old_vs;
  sl_parity_t r_parity;
  sl_mode_t   r_mode;
  sl_parity_t w_phase;
  logic       w_hs_rise;
  logic       w_vs_rise;
  logic       w_dim;

  assign w_hs_rise = vid.VGA_HS_in & ~r_old_hs;
  assign w_vs_rise = vid.VGA_VS_in & ~r_old_vs;
  assign w_dim     = (r_parity == PAR_ODD) && (r_mode != SL_OFF);

`ifdef VIDEO_SCANLINES_ALTPHASE_EN
  sl_parity_t r_phase;

  always_ff @(posedge CLK_VIDEO or posedge reset) begin
    if (reset)
      r_phase <= PAR_EVEN;
    else if (vid.CE_PIXEL && w_vs_rise)
      r_phase <= (r_phase == PAR_EVEN) ? PAR_ODD : PAR_EVEN;
  end

  assign w_phase = r_phase;
`else
  assign w_phase = PAR_EVEN;
`endif

  always_ff @(posedge CLK_VIDEO or posedge reset) begin
    if (reset) begin
      vid.CE_PIXEL_out <= 1'b0;
      vid.VGA_HS       <= 1'b0;
      vid.VGA_VS       <= 1'b0;
      vid.VGA_DE       <= 1'b0;
      r_old_hs         <= 1'b0;
      r_old_vs         <= 1'b0;
      r_parity         <= PAR_EVEN;
      r_mode           <= SL_OFF;
    end else begin
      vid.CE_PIXEL_out <= vid.CE_PIXEL;
      if (vid.CE_PIXEL) begin
        vid.VGA_HS <= vid.VGA_HS_in;
        vid.VGA_VS <= vid.VGA_VS_in;
        vid.VGA_DE <= vid.VGA_DE_in;
        r_old_hs   <= vid.VGA_HS_in;
        r_old_vs   <= vid.VGA_VS_in;
        // Frame start resynchronises parity, so it beats a coincident line start.
        if (w_vs_rise) begin
          r_mode   <= sl_mode_t'(vid.scanlines);
          r_parity <= w_phase;
        end else if (w_hs_rise) begin
          r_parity <= (r_parity == PAR_EVEN) ? PAR_ODD : PAR_EVEN;
        end
      end
    end
  end

  scanline_dim u_dim_r (
    .clk    (CLK_VIDEO),
    .rst    (reset),
    .i_ce   (vid.CE_PIXEL),
    .i_c    (vid.VGA_R_in),
    .i_dim  (w_dim),
    .i_mode (r_mode),
    .i_de   (vid.VGA_DE_in),
    .o_c    (vid.VGA_R)
  );

  scanline_dim u_dim_g (
    .clk    (CLK_VIDEO),
    .rst    (reset),
    .i_ce   (vid.CE_PIXEL),
    .i_c    (vid.VGA_G_in),
    .i_dim  (w_dim),
    .i_mode (r_mode),
    .i_de   (vid.VGA_DE_in),
    .o_c    (vid.VGA_G)
  );

  scanline_dim u_dim_b (
    .clk    (CLK_VIDEO),
    .rst    (reset),
    .i_ce   (vid.CE_PIXEL),
    .i_c    (vid.VGA_B_in),
    .i_dim  (w_dim),
    .i_mode (r_mode),
    .i_de   (vid.VGA_DE_in),
    .o_c    (vid.VGA_B)
  );

endmodule
`default_nettype wire

// File: tb/tb_video_scanlines.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_video_scanlines                                                         |
// | Random frames against a line/frame-counting model with a scoreboard.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_video_scanlines;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  video_scanlines_if vid();

  video_scanlines dut (
    .CLK_VIDEO (clk),
    .reset     (reset),
    .vid       (vid)
  );

`ifdef VIDEO_SCANLINES_ALTPHASE_EN
  localparam bit c_alt = 1'b1;
`else
  localparam bit c_alt = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [26:0] exp_q[$];

  // Model state: line index inside the current frame, frame count, latched percentage.
  int m_mode, m_line, m_frames, m_phase;
  bit m_old_hs, m_old_vs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dimmed(input int c, input int mode);
    case (mode)
      1:       return c / 2 + c / 4;
      2:       return c / 2;
      3:       return c / 4;
      default: return c;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_line = 0; m_frames = 0; m_phase = 0;
    m_old_hs = 0; m_old_vs = 0;
    exp_q.delete();
  endtask

  task automatic model_pixel(input int r, input int g, input int b,
                             input bit hs, input bit vs, input bit de, input int sl);
    bit dim;
    int er, eg, eb;
    dim = (((m_line + m_phase) % 2) == 1) && (m_mode != 0);
    er = !de ? 0 : (dim ? dimmed(r, m_mode) : r);
    eg = !de ? 0 : (dim ? dimmed(g, m_mode) : g);
    eb = !de ? 0 : (dim ? dimmed(b, m_mode) : b);
    exp_q.push_back({er[7:0], eg[7:0], eb[7:0], hs, vs, de});
    if (vs && !m_old_vs) begin
      m_mode   = sl;
      m_phase  = c_alt ? (m_frames % 2) : 0;
      m_frames = m_frames + 1;
      m_line   = 0;
    end else if (hs && !m_old_hs) begin
      m_line = m_line + 1;
    end
    m_old_hs = hs;
    m_old_vs = vs;
  endtask

  task automatic check_outputs_zero();
    check("reset_rgb", {8'h0, vid.VGA_R, vid.VGA_G, vid.VGA_B}, 32'h0);
    check("reset_sync_de_ce",
          {28'h0, vid.VGA_HS, vid.VGA_VS, vid.VGA_DE, vid.CE_PIXEL_out}, 32'h0);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #1;
    reset = 1'b1;
    vid.CE_PIXEL = 1'b0;
    model_reset();
    #1 check_outputs_zero();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drive_pixel(input int ce_div, input int r, input int g, input int b,
                             input bit hs, input bit vs, input bit de, input int sl);
    int idle;
    idle = ce_div - 1;
    if ($urandom_range(0, 15) == 0) idle = idle + 3;
    repeat (idle) begin
      @(posedge clk); #1;
      vid.CE_PIXEL = 1'b0;
    end
    @(posedge clk); #1;
    vid.CE_PIXEL  = 1'b1;
    vid.scanlines = sl[1:0];
    vid.VGA_R_in  = r[7:0];
    vid.VGA_G_in  = g[7:0];
    vid.VGA_B_in  = b[7:0];
    vid.VGA_HS_in = hs;
    vid.VGA_VS_in = vs;
    vid.VGA_DE_in = de;
    model_pixel(r, g, b, hs, vs, de, sl);
  endtask

  // solid < 0 selects random colours; rst_line >= 0 pulses reset mid-line.
  task automatic frame(input int lines, input int ppl, input int ce_div, input int vs_off,
                       input int sl_a, input int sl_b, input int change_line,
                       input int rst_line, input int solid);
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < ppl; p++) begin
        bit hs, vs, de;
        int r, g, b, sl;
        hs = (p < 2);
        vs = ((l == 0) && (p >= vs_off)) || (l == 1);
        de = (l >= 2) && (p >= 3) && (p < ppl - 1);
        r  = (solid >= 0) ? solid : int'($urandom_range(0, 255));
        g  = (solid >= 0) ? solid : int'($urandom_range(0, 255));
        b  = (solid >= 0) ? solid : int'($urandom_range(0, 255));
        sl = ((change_line >= 0) && (l >= change_line)) ? sl_b : sl_a;
        if ((l == rst_line) && (p == ppl / 2)) reset_pulse();
        drive_pixel(ce_div, r, g, b, hs, vs, de, sl);
      end
    end
  endtask

  // CE_PIXEL and reset as seen by the active edge, for the trailing-enable check.
  logic ce_prev  = 1'b0;
  logic rst_prev = 1'b1;
  always @(posedge clk) begin
    ce_prev  = vid.CE_PIXEL;
    rst_prev = reset;
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("ce_out", {31'h0, vid.CE_PIXEL_out}, {31'h0, (rst_prev ? 1'b0 : ce_prev)});
      if (vid.CE_PIXEL_out) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 32'h1, 32'h0);
        end else begin
          logic [26:0] e;
          e = exp_q.pop_front();
          check("pixel_rgb_hs_vs_de",
                {5'h0, vid.VGA_R, vid.VGA_G, vid.VGA_B, vid.VGA_HS, vid.VGA_VS, vid.VGA_DE},
                {5'h0, e});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vid.CE_PIXEL  = 1'b0;
    vid.scanlines = 2'd0;
    vid.VGA_R_in  = 8'h0;
    vid.VGA_G_in  = 8'h0;
    vid.VGA_B_in  = 8'h0;
    vid.VGA_HS_in = 1'b0;
    vid.VGA_VS_in = 1'b0;
    vid.VGA_DE_in = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_outputs_zero();
    reset = 1'b0;

    frame(8, 12, 4, 0, 0, 0, -1, -1, 200);
    frame(8, 12, 2, 0, 2, 2, -1, -1, 255);
    frame(8, 12, 2, 1, 2, 2, -1, -1, 255);
    frame(8, 12, 1, 0, 1, 3, 4, -1, 255);
    frame(8, 12, 1, 0, 3, 3, -1, -1, 255);
    frame(8, 12, 3, 5, 3, 3, -1, -1, 255);
    for (int i = 0; i < 10; i++) begin
      frame(6 + int'($urandom_range(0, 4)), 10 + int'($urandom_range(0, 6)),
            1 + int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 1) ? 3 : -1, -1, -1);
    end
    frame(8, 12, 2, 0, 2, 2, -1, 4, -1);
    frame(8, 12, 2, 0, 1, 1, -1, -1, -1);
    frame(8, 12, 1, 0, 3, 3, -1, -1, -1);

    repeat (10) begin
      @(posedge clk); #1;
      vid.CE_PIXEL = 1'b0;
    end
    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
